// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and FSM state encoding for transmitter and receiver
package uart_pkg;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam int DEFAULT_DATA_BITS = 8;
  localparam int DEFAULT_STOP_BITS = 1;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_START  = 3'd1;
  localparam state_t S_DATA   = 3'd2;
  localparam state_t S_PARITY = 3'd3;
  localparam state_t S_STOP   = 3'd4;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter with one-entry holding register, LSB first, optional even parity (UART_TX_PARITY_EN)
// ports: clk, rst (sync, active-high), baud_tick (one strobe per bit period),
//        tx_data/tx_valid/tx_ready (byte handshake), tx (serial line, idle high),
//        tx_busy (frame in progress), tx_done (pulse at end of last stop bit)
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS,
  parameter int STOP_BITS = DEFAULT_STOP_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int CW = $clog2(DATA_BITS);
  localparam int SW = $clog2(STOP_BITS + 1);
  state_t state = S_IDLE;
  logic [DATA_BITS-1:0] hold = '0;
  logic [DATA_BITS-1:0] shifter = '0;
  logic hold_full = 1'b0;
  logic [CW-1:0] bit_cnt = '0;
  logic [SW-1:0] stop_cnt = '0;
  logic line = IDLE_LEVEL;
  logic done_q = 1'b0;
`ifdef UART_TX_PARITY_EN
  logic par = 1'b0;
`endif
  logic accept, stop_last, unload;
  assign tx_ready = !hold_full;
  assign accept = tx_valid && tx_ready;
  assign stop_last = stop_cnt == SW'(STOP_BITS - 1);
  // the held byte moves to the shifter from IDLE, or straight out of the last stop bit for gapless frames
  assign unload = baud_tick && hold_full && (state == S_IDLE || (state == S_STOP && stop_last));
  assign tx = line;
  assign tx_busy = state != S_IDLE;
  assign tx_done = done_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      hold <= '0;
      shifter <= '0;
      hold_full <= 1'b0;
      bit_cnt <= '0;
      stop_cnt <= '0;
      line <= IDLE_LEVEL;
      done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (accept) hold <= tx_data;
      hold_full <= unload ? accept : (hold_full | accept);
      if (baud_tick) begin
        case (state)
          S_IDLE: ;
          S_START: begin
            line <= shifter[0];
            bit_cnt <= '0;
            state <= S_DATA;
          end
          S_DATA: begin
            if (bit_cnt != CW'(DATA_BITS - 1)) begin
              shifter <= shifter >> 1;
              line <= shifter[1];
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
`ifdef UART_TX_PARITY_EN
              line <= par;
              state <= S_PARITY;
`else
              line <= IDLE_LEVEL;
              stop_cnt <= '0;
              state <= S_STOP;
`endif
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            line <= IDLE_LEVEL;
            stop_cnt <= '0;
            state <= S_STOP;
          end
`endif
          S_STOP: begin
            if (stop_last) begin
              done_q <= 1'b1;
              state <= S_IDLE;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
          default: begin
            line <= IDLE_LEVEL;
            state <= S_IDLE;
          end
        endcase
        // start bit of the next frame overrides the IDLE/STOP defaults above
        if (unload) begin
          line <= ~IDLE_LEVEL;
          shifter <= hold;
          state <= S_START;
`ifdef UART_TX_PARITY_EN
          par <= ^hold;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized self-checking bench comparing the serial stream against frames built from sent bytes
module tb_uart_tx;
  localparam int DB = 8;
  localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = 1 + DB + PB + SB;
  logic clk = 1'b0, rst = 1'b1, baud_tick = 1'b0, tx_valid = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic tx_ready, tx, tx_busy, tx_done;
  int vectors = 0, miscompares = 0;
  int period = 4, tick_en = 0;
  logic rec[$];
  int dones[$];
  int acc = 0, busy_hits = 0;
  uart_tx #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  initial begin
    int c = 0;
    forever begin
      @(negedge clk);
      if (tick_en != 0) begin
        c++;
        baud_tick = (c % period) == 0;
      end else begin
        c = 0;
        baud_tick = 1'b0;
      end
    end
  end
  always @(posedge clk) begin
    logic t;
    t = baud_tick;
    if (!rst && tx_valid && tx_ready) acc++;
    #1;
    if (t) rec.push_back(tx);
    if (tx_done) dones.push_back(rec.size() - 1);
    if (tx_busy) busy_hits++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    rec.delete();
    dones.delete();
    acc = 0;
    busy_hits = 0;
  endtask
  task automatic send(input logic [DB-1:0] b, input bit junk);
    tx_valid = 1'b1;
    for (int n = 0; n < 5000; n++) begin
      if (tx_ready) begin
        tx_data = b;
        @(negedge clk);
        return;
      end
      tx_data = junk ? DB'($urandom) : b;
      @(negedge clk);
    end
    chk("send_timeout", 0, 1);
  endtask
  task automatic wait_done(input int n);
    for (int i = 0; i < 20000 && dones.size() < n; i++) @(negedge clk);
    chk("done_wait", dones.size() >= n, 1);
    repeat (3 * period) @(negedge clk);
  endtask
  task automatic verify(input logic [7:0] bytes[$], input string tag);
    logic e[$];
    int k = -1;
    foreach (bytes[i]) begin
      e.push_back(1'b0);
      for (int b = 0; b < DB; b++) e.push_back(bytes[i][b]);
      if (PB != 0) e.push_back(^bytes[i]);
      for (int s = 0; s < SB; s++) e.push_back(1'b1);
    end
    foreach (rec[i]) if (k < 0 && rec[i] == 1'b0) k = i;
    chk({tag, " start_found"}, k >= 0, 1);
    if (k < 0) return;
    foreach (e[i]) chk({tag, " bit"}, (k + i < rec.size()) ? rec[k + i] : 1'bx, e[i]);
    for (int i = k + e.size(); i < rec.size(); i++) chk({tag, " idle_after"}, rec[i], 1);
    chk({tag, " done_count"}, dones.size(), bytes.size());
    foreach (dones[i]) chk({tag, " done_at"}, dones[i], k + FL * (i + 1));
    chk({tag, " accepts"}, acc, bytes.size());
  endtask
  initial begin
    logic [7:0] q[$];
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    rst = 1'b0;
    @(negedge clk);
    period = 4;
    tick_en = 1;
    clr();
    repeat (80) @(negedge clk);
    chk("idle_ticks", rec.size() >= 19, 1);
    foreach (rec[i]) chk("idle_tx", rec[i], 1);
    chk("idle_busy", busy_hits, 0);
    chk("idle_done", dones.size(), 0);
    clr();
    send(8'h55, 1'b0);
    tx_valid = 1'b0;
    repeat (2 * period) @(negedge clk);
    chk("busy_mid", tx_busy, 1);
    wait_done(1);
    q = '{8'h55};
    verify(q, "single");
    clr();
    send(8'hA5, 1'b0);
    chk("ready_low_full", tx_ready, 0);
    send(8'h3C, 1'b1);
    tx_valid = 1'b0;
    wait_done(2);
    q = '{8'hA5, 8'h3C};
    verify(q, "b2b");
    for (int r = 0; r < 3; r++) begin
      period = $urandom_range(2, 6);
      repeat (2 * period) @(negedge clk);
      clr();
      q.delete();
      for (int i = 0; i < 5; i++) q.push_back(8'($urandom));
      foreach (q[i]) send(q[i], 1'b1);
      tx_valid = 1'b0;
      wait_done(q.size());
      verify(q, "random");
    end
`ifdef UART_TX_PARITY_EN
    period = 4;
    repeat (8) @(negedge clk);
    clr();
    send(8'h07, 1'b0);
    send(8'h55, 1'b1);
    tx_valid = 1'b0;
    wait_done(2);
    q = '{8'h07, 8'h55};
    verify(q, "parity");
`endif
    period = 4;
    repeat (8) @(negedge clk);
    clr();
    send(8'($urandom), 1'b0);
    send(8'($urandom), 1'b1);
    tx_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_ready", tx_ready, 1);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_done", dones.size(), 0);
    clr();
    repeat (80) @(negedge clk);
    foreach (rec[i]) chk("post_rst_tx", rec[i], 1);
    chk("post_rst_done", dones.size(), 0);
    chk("post_rst_busy", busy_hits, 0);
    tick_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
